// File: rtl/hilo_div_if.sv
// Request/result bundle between the execute stage and the HI/LO divider.
// master = EX side, slave = divider.
interface hilo_div_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                annul_i;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// One-bit-per-cycle restoring divider producing {HI = remainder, LO = quotient}
// for DIV/DIVU, with a stall request held while the divide is in flight.
module hilo_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  hilo_div_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dividend_q;
  logic [DATA_W-1:0]   divisor_q;
  logic [DATA_W-1:0]   rem_q;
  logic                sign1_q;
  logic                sign2_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic                neg1_d;
  logic                neg2_d;
  logic [DATA_W-1:0]   abs1_d;
  logic [DATA_W-1:0]   abs2_d;
  logic [DATA_W:0]     shifted_d;
  logic [DATA_W:0]     diff_d;
  logic [DATA_W-1:0]   quo_fix_d;
  logic [DATA_W-1:0]   rem_fix_d;

  assign neg1_d = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign neg2_d = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign abs1_d = neg1_d ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2_d = neg2_d ? -bus.opdata2_i : bus.opdata2_i;

  // dividend_q doubles as the quotient: dividend bits shift out the top while
  // quotient bits shift in at the bottom.
  assign shifted_d = {rem_q, dividend_q[DATA_W-1]};
  assign diff_d    = shifted_d - {1'b0, divisor_q};

  // Sign flags are only ever set for DIV, so DIVU passes through untouched.
  assign quo_fix_d = (sign1_q ^ sign2_q) ? -dividend_q : dividend_q;
  assign rem_fix_d = sign1_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state_q <= ST_BYZERO;
            end else begin
              state_q    <= ST_ON;
              cnt_q      <= '0;
              dividend_q <= abs1_d;
              divisor_q  <= abs2_d;
              rem_q      <= '0;
              sign1_q    <= neg1_d;
              sign2_q    <= neg2_d;
            end
          end
        end
        ST_BYZERO: begin
          if (bus.annul_i) begin
            state_q <= ST_FREE;
          end else begin
            state_q  <= ST_END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        ST_ON: begin
          if (bus.annul_i) begin
            state_q <= ST_FREE;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            if (!diff_d[DATA_W]) begin
              rem_q      <= diff_d[DATA_W-1:0];
              dividend_q <= {dividend_q[DATA_W-2:0], 1'b1};
            end else begin
              rem_q      <= shifted_d[DATA_W-1:0];
              dividend_q <= {dividend_q[DATA_W-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q  <= ST_END;
            result_q <= {rem_fix_d, quo_fix_d};
            ready_q  <= 1'b1;
          end
        end
        ST_END: begin
          if (!bus.start_i) begin
            state_q  <= ST_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= ST_FREE;
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i && (state_q != ST_END) && !bus.annul_i;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: DIVU/DIV results, latency, stall, divide by
// zero, annul and asynchronous reset.
module tb_hilo_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  hilo_div_if #(.DATA_W(32)) bus ();

  hilo_div_ctrl #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launches a divide and waits for ready; edges = number of posedges seen
  // including E0 (34 for a full divide, 2 for divide-by-zero, -1 on timeout).
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic [63:0] res, output bit stall_ok);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    #1;
    stall_ok = bus.stallreq_o;
    edges    = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = ~b;
        bus.signed_div_i = ~sgn;
      end
      if (bus.ready_o === 1'b1) begin
        edges = k;
        break;
      end
      if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    res = bus.result_o;
    $display("div sgn=%0d %h / %h -> result=%h after %0d edges", sgn, a, b, res, edges);
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0 || bus.stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b result=%h stall=%b, required 0/0/0",
               bus.ready_o, bus.result_o, bus.stallreq_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b result=%h, required 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_divu();
    logic [31:0] va[4] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd5};
    logic [31:0] vb[4] = '{32'd7, 32'd2, 32'd1, 32'hFFFFFFFF};
    logic [63:0] ve[4] = '{{32'd2, 32'd14}, {32'd1, 32'h7FFFFFFC},
                           {32'd0, 32'hFFFFFFFF}, {32'd5, 32'd0}};
    int edges; logic [63:0] res; bit stall_ok;
    for (int i = 0; i < 4; i++) begin
      do_div(1'b0, va[i], vb[i], edges, res, stall_ok);
      n_checks++;
      if (edges !== 34) begin
        n_fail++; $display("FAIL divu_latency[%0d]: edges=%0d, required 34", i, edges);
      end
      n_checks++;
      if (stall_ok !== 1'b1) begin
        n_fail++; $display("FAIL divu_stall_busy[%0d]: stall dropped early, required high E0..E32", i);
      end
      n_checks++;
      if (res !== ve[i]) begin
        n_fail++; $display("FAIL divu_result[%0d]: got %h, required %h", i, res, ve[i]);
      end
      n_checks++;
      if (bus.stallreq_o !== 1'b0) begin
        n_fail++; $display("FAIL divu_stall_ready[%0d]: stall=%b, required 0", i, bus.stallreq_o);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== ve[i]) begin
        n_fail++; $display("FAIL divu_hold[%0d]: ready=%b result=%h, required 1/%h",
                           i, bus.ready_o, bus.result_o, ve[i]);
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
        n_fail++; $display("FAIL divu_release[%0d]: ready=%b result=%h, required 0/0",
                           i, bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] va[4] = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'hFFFFFFF9};
    logic [31:0] vb[4] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [63:0] ve[4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h0, 32'h80000000},
                           {32'd1, 32'hFFFFFFFD}, {32'hFFFFFFFF, 32'd3}};
    int edges; logic [63:0] res; bit stall_ok;
    for (int i = 0; i < 4; i++) begin
      do_div(1'b1, va[i], vb[i], edges, res, stall_ok);
      n_checks++;
      if (edges !== 34) begin
        n_fail++; $display("FAIL div_latency[%0d]: edges=%0d, required 34", i, edges);
      end
      n_checks++;
      if (res !== ve[i]) begin
        n_fail++; $display("FAIL div_result[%0d]: got %h, required %h", i, res, ve[i]);
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_byzero();
    int edges; logic [63:0] res; bit stall_ok;
    do_div(1'b1, 32'h1234, 32'h0, edges, res, stall_ok);
    n_checks++;
    if (edges !== 2) begin
      n_fail++; $display("FAIL byzero_latency: edges=%0d, required 2", edges);
    end
    n_checks++;
    if (res !== 64'h0 || bus.stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL byzero_result: result=%h stall=%b, required 0/0", res, bus.stallreq_o);
    end
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL end_ignores_annul: ready=%b, required 1", bus.ready_o);
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL byzero_release: ready=%b, required 0", bus.ready_o);
    end
    bus.opdata2_i = 32'h0;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b1;
    #1;
    n_checks++;
    if (bus.stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL annul_stall: stall=%b, required 0", bus.stallreq_o);
    end
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL byzero_annul: ready=%b, required 0", bus.ready_o);
    end
    $display("byzero annul: ready=%b", bus.ready_o);
  endtask

  task automatic test_annul();
    int edges; int ready_seen; logic [63:0] res; bit stall_ok;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    ready_seen  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.ready_o === 1'b1) ready_seen++;
    end
    n_checks++;
    if (ready_seen !== 0) begin
      n_fail++; $display("FAIL annul_no_result: ready high %0d cycles, required 0", ready_seen);
    end
    do_div(1'b0, 32'd9, 32'd3, edges, res, stall_ok);
    n_checks++;
    if (edges !== 34 || res !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL annul_next_div: edges=%0d result=%h, required 34/%h",
                         edges, res, {32'd0, 32'd3});
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int edges; logic [63:0] res; bit stall_ok;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd9;
    bus.start_i      = 1'b1;
    repeat (16) @(posedge clk);
    #2;
    bus.start_i = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0 || bus.stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: ready=%b result=%h stall=%b, required 0/0/0",
                         bus.ready_o, bus.result_o, bus.stallreq_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd7, edges, res, stall_ok);
    n_checks++;
    if (edges !== 34 || res !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL reset_then_div: edges=%0d result=%h, required 34/%h",
                         edges, res, {32'd2, 32'd14});
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_byzero();
    test_annul();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Multi-cycle divider controller that produces the HI/LO pair for DIV/DIVU.
- Sits beside the execute stage. Sequences a one-bit-per-cycle restoring divide and raises a stall request while busy.
- Presents {remainder, quotient} for the HI/LO write path (hi_o/lo_o/whilo_o) that flows through MEM to the HI/LO register.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high (RstEnable = 1'b1)
start_i  in  1  divide request from EX; held high until the result is consumed
annul_i  in  1  cancel in-flight divide (branch-delay squash / flush)
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
opdata1_i  in  DATA_W  dividend, sampled on the accepting edge
opdata2_i  in  DATA_W  divisor, sampled on the accepting edge
result_o  out  2*DATA_W  {HI = remainder, LO = quotient}
ready_o  out  1  result valid
stallreq_o  out  1  combinational stall request to pipeline control

Behaviour:
- Reset (async, any state, including mid-divide): state = FREE, cnt = 0, result_o = 0, ready_o = 0, internal dividend/divisor registers = 0.
- State encoding: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON. cnt=0. Latch |dividend| and |divisor| into the internal registers, and latch both sign bits.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- Operand conditioning: if signed_div_i=1 and an operand's MSB is 1, use its two's complement. If signed_div_i=0, use the operands unchanged.
- ON:
  - annul_i=1 -> FREE, no result produced.
  - cnt<DATA_W -> one restoring step per edge:
    - Partial remainder shifts left with the next dividend bit.
    - Trial subtract of the divisor.
    - Quotient bit = 1 if the trial is non-negative (keep the difference), else 0 (keep the shifted value).
    - cnt increments.
  - cnt==DATA_W -> END. Apply sign correction (below), load result_o, set ready_o=1.
- Sign correction (signed only):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. No trap.
- BYZERO: next edge -> END with result_o=0, ready_o=1. annul_i=1 in BYZERO -> FREE instead.
- END:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0 -> FREE; ready_o=0 and result_o=0 on the same edge.
  - annul_i in END is ignored.
- Latency: accepting edge = E0. ON iterations occur on E1..E32 (cnt reaches 32 after E32). ON->END on E33, so ready_o is high after E33. Divide-by-zero: ready_o high after E1.
- stallreq_o (combinational): 1 when start_i=1 and state!=END and annul_i=0; else 0. It therefore drops in the cycle ready_o is seen.
- Changes to opdata*_i or signed_div_i after E0 have no effect on an in-flight divide.
- A new divide can be accepted only from FREE, i.e. at least one cycle with start_i=0 between back-to-back divides.

Test Plan:
- DIVU 100 / 7, start held -> stallreq_o high during E0..E32; ready_o rises after E33 with result_o = {0x00000002, 0x0000000E}; start_i drop -> next edge ready_o=0, result_o=0.
- DIV signed -7 / 2 (0xFFFFFFF9 / 0x2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also check DIVU of the same operands gives {0x00000001, 0x7FFFFFFC}.
- Divisor 0 (DIV 0x1234 / 0) -> BYZERO then END; ready_o high after E1, result_o = 0, stallreq_o low from that cycle.
- Annul: start DIVU 0xFFFFFFFF / 3, assert annul_i for one cycle at E10 -> state FREE, ready_o never asserts; a following DIVU 9/3 (after start_i low one cycle) gives {0, 3} after its own 33 edges.
- Async reset at E15 of a divide, asserted between clock edges -> result_o, ready_o, stallreq_o (with start_i low) go to 0 immediately without a clock edge; after release, FREE with cnt=0.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> result_o = {0x00000000, 0x80000000}, ready_o after E33.
